// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared constants, button FSM states and encode helpers for the memory game
//
// Purpose : button/LED count and code width shared by the display, shift
//           register, input handler and button encoder; button FSM state
//           type; one-hot helpers used by the encoder.
// Ports   : none (package).

package memory_game_pkg;

   localparam int NUM_BTNS = 8;
   localparam int CODE_W   = $clog2(NUM_BTNS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HELD     = 2'd1,
      WAIT_REL = 2'd2
   } btn_state_t;

   // Index of the set bit; only meaningful when vec is one-hot.
   function automatic logic [CODE_W-1:0] onehot_to_idx(input logic [NUM_BTNS-1:0] vec);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (vec[i]) begin
            idx = idx | CODE_W'(i);
         end
      end
      return idx;
   endfunction

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   function automatic logic is_onehot(input logic [NUM_BTNS-1:0] vec);
      return (vec != '0) && ((vec & (vec - NUM_BTNS'(1))) == '0);
   endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// rtl/btn_sync_debounce.sv - two-flop synchroniser and whole-vector debouncer for the buttons
//
// Purpose : brings raw buttons into the clock domain and only lets the
//           vector through once it has been stable for DEBOUNCE_CYCLES.
// Ports   : clk       - system clock
//           rst_n     - asynchronous active-low reset
//           btn_i     - raw asynchronous buttons, active-high
//           deb_o     - debounced button vector
//           deb_any_o - high while deb_o is non-zero (same cycle as deb_o)
//           deb_upd_o - one-cycle pulse in the cycle deb_o was (re)written

module btn_sync_debounce #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] btn_i,
   output logic [WIDTH-1:0] deb_o,
   output logic             deb_any_o,
   output logic             deb_upd_o
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] cand_q;
   logic [WIDTH-1:0] deb_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             deb_any_q;
   logic             deb_upd_q;
   logic             stable;
   logic             hit;

   assign stable = (sync_q == cand_q);
   // The counter passes CNT_HIT exactly once per stable run, so deb is written once per run.
   assign hit    = stable && (cnt_q == CNT_HIT);

   always_comb begin
      cnt_d = cnt_q;
      if (!stable) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q    <= '0;
         sync_q    <= '0;
         cand_q    <= '0;
         deb_q     <= '0;
         cnt_q     <= '0;
         deb_any_q <= 1'b0;
         deb_upd_q <= 1'b0;
      end else begin
         meta_q    <= btn_i;
         sync_q    <= meta_q;
         cand_q    <= sync_q;
         cnt_q     <= cnt_d;
         deb_upd_q <= hit;
         if (hit) begin
            deb_q     <= cand_q;
            deb_any_q <= |cand_q;
         end
      end
   end

   assign deb_o     = deb_q;
   assign deb_any_o = deb_any_q;
   assign deb_upd_o = deb_upd_q;

endmodule

// File: rtl/button_encoder.sv
// rtl/button_encoder.sv - debounced push-button to 3-bit code encoder with chord rejection
//
// Purpose : turns one clean button press into a code plus a one-cycle
//           valid strobe; chords are rejected and flagged.
// Ports   : clk         - system clock
//           rst_n       - asynchronous active-low reset
//           en          - accept new presses (only sampled in IDLE)
//           btn         - raw asynchronous buttons, active-high
//           code        - index of the last accepted button, held
//           code_valid  - one-cycle pulse per accepted press
//           multi_press - one-cycle pulse when a chord is detected
//           btn_down    - high while the debounced vector is non-zero

module button_encoder #(
   parameter int NUM_BTNS        = memory_game_pkg::NUM_BTNS,
   parameter int CODE_W          = memory_game_pkg::CODE_W,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [NUM_BTNS-1:0] btn,
   output logic [CODE_W-1:0]   code,
   output logic                code_valid,
   output logic                multi_press,
   output logic                btn_down
);

   import memory_game_pkg::*;

   logic [NUM_BTNS-1:0] deb;
   logic                deb_any;
   logic                deb_upd;

   // deb_r_q is a pipeline stage between the debouncer and the FSM; it sets
   // press-to-strobe latency at DEBOUNCE_CYCLES+3 edges.
   logic [NUM_BTNS-1:0] deb_r_q;
   // Armed once a zero vector has been confirmed by the debouncer. A button
   // held through reset rises out of a zero that was never debounced, so it
   // is parked in WAIT_REL instead of being accepted.
   logic                armed_q;

   btn_state_t          state_q,      state_d;
   logic [NUM_BTNS-1:0] held_q,       held_d;
   logic [CODE_W-1:0]   code_q,       code_d;
   logic                code_valid_q, code_valid_d;
   logic                multi_q,      multi_d;

   btn_sync_debounce #(
      .WIDTH          (NUM_BTNS),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_i    (btn),
      .deb_o    (deb),
      .deb_any_o(deb_any),
      .deb_upd_o(deb_upd)
   );

   always_comb begin
      state_d      = state_q;
      held_d       = held_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      multi_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (deb_r_q != '0) begin
               if (!en || !armed_q) begin
                  state_d = WAIT_REL;
               end else if (is_onehot(deb_r_q)) begin
                  code_d       = onehot_to_idx(deb_r_q);
                  code_valid_d = 1'b1;
                  held_d       = deb_r_q;
                  state_d      = HELD;
               end else begin
                  multi_d = 1'b1;
                  state_d = WAIT_REL;
               end
            end
         end
         HELD: begin
            if (deb_r_q == '0) begin
               state_d = IDLE;
            end else if (deb_r_q != held_q) begin
               // Extra bit or a swap to another button without a release.
               multi_d = 1'b1;
               state_d = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (deb_r_q == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_r_q      <= '0;
         armed_q      <= 1'b0;
         state_q      <= IDLE;
         held_q       <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         multi_q      <= 1'b0;
      end else begin
         deb_r_q      <= deb;
         armed_q      <= armed_q | (deb_upd & ~(|deb));
         state_q      <= state_d;
         held_q       <= held_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         multi_q      <= multi_d;
      end
   end

   assign code        = code_q;
   assign code_valid  = code_valid_q;
   assign multi_press = multi_q;
   assign btn_down    = deb_any;

endmodule

// File: tb/tb_button_encoder.sv
// tb/tb_button_encoder.sv - directed, table-driven bench for button_encoder

module tb_button_encoder;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b0;
   logic [7:0] btn   = 8'h00;
   logic [2:0] code;
   logic       code_valid;
   logic       multi_press;
   logic       btn_down;

   int checks   = 0;
   int errors   = 0;
   int cv_cnt   = 0;
   int mp_cnt   = 0;
   int both_cnt = 0;
   int bd_cyc   = 0;

   typedef struct {
      logic [7:0] btn;
      logic       en;
      int         hold;
      int         exp_cv;
      int         exp_mp;
      int         exp_code;
      int         exp_bd;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   button_encoder #(.DEBOUNCE_CYCLES(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .btn        (btn),
      .code       (code),
      .code_valid (code_valid),
      .multi_press(multi_press),
      .btn_down   (btn_down)
   );

   always @(negedge clk) begin
      if (code_valid === 1'b1) cv_cnt++;
      if (multi_press === 1'b1) mp_cnt++;
      if (code_valid === 1'b1 && multi_press === 1'b1) both_cnt++;
      if (btn_down === 1'b1) bd_cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int nz, first, n, cv0, mp0, bd0;
      logic bd16, bd17;

      vecs[0] = '{8'h01, 1'b1, 40, 1, 0, 0, 1};
      vecs[1] = '{8'h80, 1'b1, 40, 1, 0, 7, 1};
      vecs[2] = '{8'h11, 1'b1, 40, 0, 1, 7, 1};
      vecs[3] = '{8'h08, 1'b1, 40, 1, 0, 3, 1};
      vecs[4] = '{8'h40, 1'b0, 40, 0, 0, 3, 1};
      vecs[5] = '{8'h02, 1'b1, 10, 0, 0, 3, 0};
      vecs[6] = '{8'hFF, 1'b1, 40, 0, 1, 3, 1};

      // Reset state
      tick(3);
      check("reset_code", code, 0);
      check("reset_code_valid", code_valid, 0);
      check("reset_multi_press", multi_press, 0);
      check("reset_btn_down", btn_down, 0);
      rst_n = 1'b1;
      nz = 0;
      repeat (100) begin
         tick(1);
         if (code !== 3'd0 || code_valid !== 1'b0 || multi_press !== 1'b0 || btn_down !== 1'b0) nz++;
      end
      check("idle_after_reset", nz, 0);

      // Latency of a clean press, counted from the first sampling edge (i=0)
      en = 1'b1;
      btn = 8'h04;
      first = -1; n = 0; bd16 = 1'b0; bd17 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (code_valid === 1'b1) begin
            n++;
            if (first < 0) first = i;
         end
         if (i == 16) bd16 = btn_down;
         if (i == 17) bd17 = btn_down;
      end
      check("latency_edge", first, 19);
      check("latency_pulse_count", n, 1);
      check("latency_code", code, 2);
      check("press_btn_down_before", bd16, 0);
      check("press_btn_down_after", bd17, 1);
      btn = 8'h00;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 16) bd16 = btn_down;
         if (i == 17) bd17 = btn_down;
      end
      check("release_btn_down_before", bd16, 1);
      check("release_btn_down_after", bd17, 0);

      // Table-driven presses, each followed by a debounced release
      for (int v = 0; v < 7; v++) begin
         cv0 = cv_cnt; mp0 = mp_cnt; bd0 = bd_cyc;
         btn = vecs[v].btn;
         en  = vecs[v].en;
         tick(vecs[v].hold);
         btn = 8'h00;
         tick(40);
         en = 1'b1;
         check($sformatf("vec%0d_code_valid", v), cv_cnt - cv0, vecs[v].exp_cv);
         check($sformatf("vec%0d_multi_press", v), mp_cnt - mp0, vecs[v].exp_mp);
         check($sformatf("vec%0d_code", v), code, vecs[v].exp_code);
         check($sformatf("vec%0d_btn_down_seen", v), (bd_cyc - bd0) > 0, vecs[v].exp_bd);
      end

      // Bounce on btn[5], then stable
      cv0 = cv_cnt;
      for (int i = 0; i < 10; i++) begin
         btn = (i % 2 == 0) ? 8'h20 : 8'h00;
         tick(3);
      end
      check("bounce_no_pulse", cv_cnt - cv0, 0);
      btn = 8'h20;
      tick(40);
      check("bounce_one_pulse", cv_cnt - cv0, 1);
      check("bounce_code", code, 5);
      btn = 8'h00;
      tick(40);

      // Extra button while HELD
      cv0 = cv_cnt; mp0 = mp_cnt;
      btn = 8'h01;
      tick(30);
      btn = 8'h81;
      tick(30);
      check("held_chord_code_valid", cv_cnt - cv0, 1);
      check("held_chord_multi_press", mp_cnt - mp0, 1);
      check("held_chord_code_kept", code, 0);
      btn = 8'h00;
      tick(40);
      btn = 8'h80;
      tick(30);
      check("after_chord_code", code, 7);
      check("after_chord_code_valid", cv_cnt - cv0, 2);
      btn = 8'h00;
      tick(40);

      // en gating
      cv0 = cv_cnt; mp0 = mp_cnt;
      en = 1'b0;
      btn = 8'h40;
      tick(30);
      en = 1'b1;
      tick(30);
      check("en_late_no_valid", cv_cnt - cv0, 0);
      check("en_late_no_multi", mp_cnt - mp0, 0);
      btn = 8'h00;
      tick(40);
      btn = 8'h40;
      tick(30);
      check("en_repress_valid", cv_cnt - cv0, 1);
      check("en_repress_code", code, 6);
      en = 1'b0;
      tick(10);
      btn = 8'h00;
      tick(40);
      en = 1'b1;
      check("en_drop_held_valid", cv_cnt - cv0, 1);
      check("en_drop_held_multi", mp_cnt - mp0, 0);

      // Reset while a press is held
      cv0 = cv_cnt;
      btn = 8'h04;
      tick(30);
      check("rst_hold_accepted", cv_cnt - cv0, 1);
      check("rst_hold_code", code, 2);
      rst_n = 1'b0;
      #2;
      check("rst_async_code", code, 0);
      check("rst_async_btn_down", btn_down, 0);
      tick(1);
      rst_n = 1'b1;
      cv0 = cv_cnt; mp0 = mp_cnt;
      tick(40);
      check("rst_recover_no_valid", cv_cnt - cv0, 0);
      check("rst_recover_no_multi", mp_cnt - mp0, 0);
      btn = 8'h00;
      tick(40);
      btn = 8'h04;
      tick(30);
      check("rst_repress_valid", cv_cnt - cv0, 1);
      check("rst_repress_code", code, 2);
      btn = 8'h00;
      tick(40);

      check("never_both_pulses", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
